// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: parameterised register chain with a per-stage valid
// qualifier, clock enable, synchronous clear and asynchronous active-low
// reset. DEPTH=0 makes the block a pure combinational pass-through.
//
// Optional feature macro: PIPE_REG_CHAIN_OCCUPANCY_EN
//   When defined, an extra output 'occ' reports how many stages currently
//   hold a valid beat (popcount of the valid bits). When undefined there is
//   no occ port and no counter.
module pipe_reg_chain #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 2,
  localparam int OCC_W = (DEPTH < 1) ? 1 : $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             sclr,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
  ,
  output logic [OCC_W-1:0] occ
`endif
);

  generate
    if (DEPTH == 0) begin : g_bypass
      // Zero-stage build: wires only, clock/reset/enable/clear are not used.
      assign out_data  = in_data;
      assign out_valid = in_valid;

      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst, ce, sclr};

`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
      assign occ = '0;
`endif
    end else begin : g_chain
      // Stage registers: d_reg[k] is the data held by stage k, v_reg[k] its
      // valid bit. Stage DEPTH-1 drives the outputs.
      logic [WIDTH-1:0] d_reg [DEPTH];
      logic [DEPTH-1:0] v_reg;

      // Source of each stage: stage 0 is fed from the input port, every
      // later stage from the stage in front of it.
      logic [WIDTH-1:0] d_src [DEPTH];
      logic [DEPTH-1:0] v_src;

      assign d_src[0] = in_data;
      assign v_src[0] = in_valid;

      for (genvar gi = 1; gi < DEPTH; gi++) begin : g_link
        assign d_src[gi] = d_reg[gi-1];
        assign v_src[gi] = v_reg[gi-1];
      end

      // Valid bits shift on every enabled edge, including bubbles, so that
      // latency is counted in enabled edges regardless of data content.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          v_reg <= '0;
        end else if (sclr) begin
          v_reg <= '0;
        end else if (ce) begin
          v_reg <= v_src;
        end
      end

      // Data registers load only when their source is valid; a bubble
      // leaves the previous beat in place so the output keeps the last
      // valid value while out_valid is low.
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
        always_ff @(posedge clk or negedge rst) begin
          if (!rst) begin
            d_reg[gi] <= '0;
          end else if (sclr) begin
            d_reg[gi] <= '0;
          end else if (ce && v_src[gi]) begin
            d_reg[gi] <= d_src[gi];
          end
        end
      end

      assign out_data  = d_reg[DEPTH-1];
      assign out_valid = v_reg[DEPTH-1];

`ifdef PIPE_REG_CHAIN_OCCUPANCY_EN
      // Occupancy tracks entries minus exits; it moves exactly when the
      // valid bits move, so it always equals the popcount of v_reg.
      logic [OCC_W-1:0] occ_reg;
      logic [OCC_W-1:0] occ_next;

      // Next occupancy: one beat may enter and one may leave per edge.
      always_comb begin
        occ_next = occ_reg + OCC_W'(in_valid) - OCC_W'(v_reg[DEPTH-1]);
      end

      // Occupancy counter shares the enable/clear/reset of the chain.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          occ_reg <= '0;
        end else if (sclr) begin
          occ_reg <= '0;
        end else if (ce) begin
          occ_reg <= occ_next;
        end
      end

      assign occ = occ_reg;
`endif
    end
  endgenerate

endmodule
